// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//
// Adds two WIDTH-bit operands using a single 4-bit ripple-carry slice. The
// slice handles one nibble per clock, and a registered carry links each nibble
// to the next. Operands arrive over a valid/ready handshake. The finished sum
// and carry-out leave over a second valid/ready handshake.
//
// Parameters:
//   WIDTH      operand/result width; must be a multiple of 4 and at least 8
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operands a, b, cin are presented
//   in_ready   block is idle and will accept operands
//   a, b       WIDTH-bit operands
//   cin        carry into nibble 0
//   out_valid  sum/cout hold a finished result
//   out_ready  consumer takes the result
//   sum        registered WIDTH-bit sum
//   cout       registered carry out of the top nibble
//   busy       an operation is in progress or waiting to be taken
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// four_bit_adder
//
// The team's 4-bit ripple-carry adder stage. It is purely combinational.
//
// Ports:
//   a, b   4-bit addends
//   cin    carry in
//   s      4-bit sum
//   cout   carry out of bit 3
// -----------------------------------------------------------------------------
module four_bit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];

endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic [CW-1:0]    nib_cnt;

    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic [3:0]       slice_s;
    logic             slice_c;

    // The bit offset of the current nibble is nib_cnt*4. Appending two zero
    // bits gives that offset directly, with no multiplier.
    always_comb begin
        slice_a = a_reg[{nib_cnt, 2'b00} +: 4];
        slice_b = b_reg[{nib_cnt, 2'b00} +: 4];
    end

    four_bit_adder u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_reg),
        .s    (slice_s),
        .cout (slice_c)
    );

    // Control and datapath share one sequential block. IDLE captures the
    // operands. ADD feeds one nibble per cycle through the slice and keeps the
    // carry in carry_reg, so a carry crosses at most one nibble per clock.
    // DONE holds the result until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            nib_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        nib_cnt   <= '0;
                        state     <= ADD;
                    end
                end
                ADD: begin
                    sum_reg[{nib_cnt, 2'b00} +: 4] <= slice_s;
                    carry_reg                      <= slice_c;
                    if (nib_cnt == LAST_NIB) begin
                        cout_reg <= slice_c;
                        state    <= DONE;
                    end else begin
                        nib_cnt <= nib_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_reg;
    assign cout      = cout_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
//
// Self-checking bench for nibble_serial_adder. It drives three instances
// (WIDTH 8, 16 and 32). Directed vectors use the 16-bit instance. A random
// back-to-back stream then runs on all three instances. A behavioural model
// tracks each instance through its idle, computing and holding phases. It
// derives the expected result arithmetically as a + b + cin.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder;

    logic        clk;
    logic        rst;

    logic [31:0] a_in    [3];
    logic [31:0] b_in    [3];
    logic        cin_in  [3];
    logic        iv      [3];
    logic        ordy    [3];
    logic        ir      [3];
    logic        ov      [3];
    logic        bs      [3];
    logic        co      [3];
    logic [31:0] sm      [3];

    logic [7:0]  sum8;
    logic [15:0] sum16;
    logic [31:0] sum32;

    int errors = 0;
    int checks = 0;

    // Model state for each instance. phase 0 = idle, 1 = computing, 2 = holding.
    int          m_phase  [3];
    int          m_left   [3];
    int          last_acc [3];
    logic [63:0] m_res    [3];
    logic [63:0] m_last   [3];
    int          cyc = 0;
    bit          stream_mode = 0;

    function automatic int wof(input int k);
        return (k == 0) ? 8 : ((k == 1) ? 16 : 32);
    endfunction

    nibble_serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a_in[0][7:0]), .b(b_in[0][7:0]), .cin(cin_in[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sum8), .cout(co[0]),
        .busy(bs[0])
    );

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a_in[1][15:0]), .b(b_in[1][15:0]), .cin(cin_in[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sum16), .cout(co[1]),
        .busy(bs[1])
    );

    nibble_serial_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a_in[2]), .b(b_in[2]), .cin(cin_in[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sum32), .cout(co[2]),
        .busy(bs[2])
    );

    always_comb begin
        sm[0] = {24'b0, sum8};
        sm[1] = {16'b0, sum16};
        sm[2] = sum32;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // The model advances on each clock edge, as the spec describes. An accepted
    // operation stays out of sight for NIB edges, then is held until taken.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                m_phase[k]  = 0;
                m_left[k]   = 0;
                m_last[k]   = 64'd0;
                m_res[k]    = 64'd0;
                last_acc[k] = -1;
            end
        end else begin
            cyc++;
            for (int k = 0; k < 3; k++) begin
                int w;
                logic [63:0] msk;
                w   = wof(k);
                msk = (64'd1 << w) - 64'd1;
                case (m_phase[k])
                    0: begin
                        if (iv[k]) begin
                            m_res[k] = (({32'b0, a_in[k]} & msk) + ({32'b0, b_in[k]} & msk)
                                        + {63'b0, cin_in[k]}) & ((msk << 1) | 64'd1);
                            if (stream_mode && last_acc[k] >= 0)
                                check($sformatf("w%0d accept spacing", w),
                                      64'(cyc - last_acc[k]), 64'(w / 4 + 2));
                            last_acc[k] = stream_mode ? cyc : -1;
                            m_left[k]   = w / 4;
                            m_phase[k]  = 1;
                        end
                    end
                    1: begin
                        m_left[k]--;
                        if (m_left[k] == 0) begin
                            m_phase[k] = 2;
                            m_last[k]  = m_res[k];
                        end
                    end
                    default: begin
                        if (ordy[k]) m_phase[k] = 0;
                    end
                endcase
            end
        end
    end

    // Compare every instance against the model on each falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int w;
            logic [63:0] msk;
            w   = wof(k);
            msk = (64'd1 << w) - 64'd1;
            check($sformatf("w%0d in_ready", w),  64'(ir[k]), 64'(m_phase[k] == 0));
            check($sformatf("w%0d out_valid", w), 64'(ov[k]), 64'(m_phase[k] == 2));
            check($sformatf("w%0d busy", w),      64'(bs[k]), 64'(m_phase[k] != 0));
            if (m_phase[k] != 1) begin
                check($sformatf("w%0d sum", w),  {32'b0, sm[k]}, m_last[k] & msk);
                check($sformatf("w%0d cout", w), 64'(co[k]), 64'(m_last[k][w]));
            end
        end
    end

    // Present one operand set to the 16-bit instance. Then count the edges
    // until out_valid rises. The count is bounded.
    task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                                 input logic cv, output int lat);
        @(negedge clk);
        iv[1]     = 1'b1;
        a_in[1]   = {16'b0, av};
        b_in[1]   = {16'b0, bv};
        cin_in[1] = cv;
        @(posedge clk);
        #1;
        iv[1] = 1'b0;
        lat = 0;
        while (!ov[1] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic checkOutput(input string name, input logic [15:0] es, input logic ec);
        check({name, " out_valid"}, 64'(ov[1]), 64'd1);
        check({name, " sum"},       64'(sm[1]), 64'(es));
        check({name, " cout"},      64'(co[1]), 64'(ec));
    endtask

    task automatic releaseResult(input string name);
        @(negedge clk);
        ordy[1] = 1'b1;
        @(posedge clk);
        #1;
        ordy[1] = 1'b0;
        check({name, " in_ready after take"}, 64'(ir[1]), 64'd1);
    endtask

    initial begin
        int lat;
        for (int k = 0; k < 3; k++) begin
            a_in[k] = '0; b_in[k] = '0; cin_in[k] = 1'b0; iv[k] = 1'b0; ordy[k] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready",  64'(ir[1]), 64'd1);
        check("reset out_valid", 64'(ov[1]), 64'd0);
        check("reset busy",      64'(bs[1]), 64'd0);
        check("reset sum",       64'(sm[1]), 64'd0);
        check("reset cout",      64'(co[1]), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(16'h1234, 16'h4321, 1'b0, lat);
        check("op1 latency", 64'(lat), 64'd4);
        checkOutput("op1", 16'h5555, 1'b0);
        releaseResult("op1");

        applyStimulus(16'hFFFF, 16'h0001, 1'b0, lat);
        check("op2 latency", 64'(lat), 64'd4);
        checkOutput("op2", 16'h0000, 1'b1);
        releaseResult("op2");

        applyStimulus(16'hFFFF, 16'h0000, 1'b1, lat);
        check("op3 latency", 64'(lat), 64'd4);
        checkOutput("op3", 16'h0000, 1'b1);
        releaseResult("op3");

        applyStimulus(16'h0000, 16'h0000, 1'b0, lat);
        checkOutput("op4", 16'h0000, 1'b0);
        releaseResult("op4");

        // Backpressure. The result must hold, and new operands must be ignored.
        applyStimulus(16'h0ABC, 16'h1111, 1'b1, lat);
        checkOutput("bp", 16'h1BCE, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            iv[1]     = 1'b1;
            a_in[1]   = $urandom;
            b_in[1]   = $urandom;
            cin_in[1] = 1'b1;
            @(posedge clk);
            #1;
            checkOutput("bp hold", 16'h1BCE, 1'b0);
            check("bp in_ready", 64'(ir[1]), 64'd0);
        end
        @(negedge clk);
        iv[1] = 1'b0;
        releaseResult("bp");

        // Reset asserted two edges after acceptance aborts the operation.
        @(negedge clk);
        iv[1] = 1'b1; a_in[1] = 32'h7777; b_in[1] = 32'h1111; cin_in[1] = 1'b0;
        @(posedge clk);
        #1;
        iv[1] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort sum",       64'(sm[1]), 64'd0);
        check("abort cout",      64'(co[1]), 64'd0);
        check("abort out_valid", 64'(ov[1]), 64'd0);
        check("abort busy",      64'(bs[1]), 64'd0);
        check("abort in_ready",  64'(ir[1]), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(16'h00FF, 16'h0001, 1'b0, lat);
        check("post-abort latency", 64'(lat), 64'd4);
        checkOutput("post-abort", 16'h0100, 1'b0);
        releaseResult("post-abort");

        // Random back-to-back stream on all widths.
        @(negedge clk);
        stream_mode = 1'b1;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b1; ordy[k] = 1'b1;
        end
        repeat (150) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                a_in[k]   = $urandom;
                b_in[k]   = $urandom;
                cin_in[k] = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        stream_mode = 1'b0;
        for (int k = 0; k < 3; k++) iv[k] = 1'b0;
        repeat (12) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Sequential wrapper that adds two WIDTH-bit operands 4 bits per clock by driving one instance of the team's 4-bit ripple-carry adder stage (`four_bit_adder`). It sits directly upstream of that stage: it registers operands, feeds one nibble pair plus the registered carry into the stage each cycle, and collects the nibble sums. Operands enter and results leave through valid/ready handshakes, so WIDTH-bit additions reuse a single 4-bit slice.

## Interface

Parameters:
- WIDTH, 16, operand/result width.
  - Must be a multiple of 4 and at least 8.
  - NIB = WIDTH/4 is the number of nibbles.

Ports (clock and reset first):
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a, b and cin are presented.
- in_ready  output  1  block accepts operands; equals (state == IDLE).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for nibble 0.
- out_valid  output  1  sum and cout hold a finished result; equals (state == DONE).
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  registered sum.
- cout  output  1  registered carry-out of the top nibble.
- busy  output  1  high in ADD and DONE.

## Operation

- Internal registers:
  - a_reg, b_reg: WIDTH bits each.
  - carry_reg: 1 bit.
  - sum_reg: WIDTH bits; drives `sum`.
  - cout_reg: drives `cout`.
  - nib_cnt: clog2(NIB) bits.
  - state: one of IDLE, ADD, DONE.
- Adder slice inputs:
  - A = a_reg[4*nib_cnt +: 4]
  - B = b_reg[4*nib_cnt +: 4]
  - cin = carry_reg
- IDLE:
  - On in_valid & in_ready: a_reg <= a, b_reg <= b, carry_reg <= cin, nib_cnt <= 0, next state ADD.
  - in_valid low: stay in IDLE, registers unchanged.
- ADD, each cycle:
  - sum_reg[4*nib_cnt +: 4] <= slice S.
  - carry_reg <= slice carry.
  - nib_cnt <= nib_cnt + 1.
- ADD exit: when nib_cnt == NIB-1, also cout_reg <= slice carry and next state DONE. nib_cnt is not incremented past NIB-1.
- DONE:
  - sum and cout are stable.
  - On out_ready: next state IDLE.
  - Otherwise the block holds indefinitely.
- Arithmetic: {cout, sum} = a + b + cin, computed modulo 2^(WIDTH+1). No overflow flag.
- in_valid while in_ready = 0 is ignored. Operands are not queued.
- In IDLE, sum and cout keep the last result. During ADD, sum updates nibble by nibble and is meaningful only while out_valid = 1.

## Timing

- Reset values (applied asynchronously on rst high, held while rst is high):
  - state = IDLE, nib_cnt = 0.
  - a_reg, b_reg, sum_reg = 0; carry_reg, cout_reg = 0.
  - out_valid = 0, busy = 0, sum = 0, cout = 0.
  - in_ready = 1.
- Reset mid-operation (ADD or DONE) aborts the operation. The result is discarded and no out_valid pulse occurs.
- Latency: operands accepted at edge k give out_valid = 1 after edge k+NIB. For WIDTH=16 that is 4 cycles.
- Throughput: at most one operation per NIB+2 cycles, since in_ready rises only the cycle after DONE handshakes.
- Handshakes:
  - Transfer occurs on a rising edge where valid & ready are both high.
  - out_valid, sum and cout must not change while out_valid = 1 and out_ready = 0.
- Simultaneous in_valid and out_ready in DONE: the result handshakes. The new operand is not accepted until IDLE.
- The carry path is combinational through the slice only. No carry crosses more than one nibble per cycle.

## Test plan

- WIDTH=16, a=0x1234, b=0x4321, cin=0:
  - sum=0x5555, cout=0.
  - out_valid rises exactly 4 cycles after acceptance.
- a=0xFFFF, b=0x0001, cin=0: sum=0x0000, cout=1 (carry ripples through all four nibbles across cycles).
- a=0xFFFF, b=0x0000, cin=1: sum=0x0000, cout=1. Also a=0, b=0, cin=0: sum=0, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - out_valid, sum and cout stay constant; in_ready stays 0.
  - A second in_valid is ignored.
  - After out_ready=1 the block returns to IDLE with in_ready=1.
- Reset mid-ADD, asserted 2 cycles after acceptance:
  - All outputs read 0 immediately and in_ready=1.
  - The next op a=0x00FF, b=0x0001 yields sum=0x0100, cout=0.
- Random back-to-back operands with out_ready=1 and WIDTH in {8, 16, 32}:
  - Every result matches a + b + cin.
  - Consecutive acceptances are spaced exactly NIB+2 cycles apart.
